// File: rtl/fc_layer_engine.sv
`default_nettype none
// fc_layer_engine: fully-connected layer y[j] = sat(sum_i W[j][i]*x[i] + b[j]) over one shared word memory.
// Optional macro FC_RELU_EN clamps negative outputs to zero at write-back.
module fc_layer_engine #(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int N_IN     = 120,
  parameter int N_OUT    = 84,
  parameter int ADDR_W   = 14,
  parameter int IN_BASE  = 0,
  parameter int W_BASE   = 120,
  parameter int B_BASE   = 10200,
  parameter int OUT_BASE = 10284
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data
);

  localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1;
  localparam int IDX_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int ROW_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_IN  = 3'd1,
    S_ROW_BIAS = 3'd2,
    S_ROW_MAC  = 3'd3,
    S_STORE    = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [ADDR_W-1:0]         w_addr_q, w_addr_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      pend_q, pend_d;
  logic signed [DATA_W-1:0]  x_buf_q [N_IN];
  logic signed [DATA_W-1:0]  x_buf_d [N_IN];

  logic signed [DATA_W-1:0]   rd_data_s;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_shr;
  logic [DATA_W-1:0]          y_sat;
  logic [DATA_W-1:0]          y_out;
  logic                       rd_ok;

  assign rd_data_s = signed'(mem_rd_data);
  // Only a response to our own pending request is accepted.
  assign rd_ok     = pend_q && mem_rd_valid;

  // Output conversion: floor shift back to FRAC_W, then clamp to the word range.
  always_comb begin
    prod    = (2*DATA_W)'(x_buf_q[idx_q]) * (2*DATA_W)'(rd_data_s);
    acc_shr = acc_q >>> FRAC_W;
    if ((&acc_shr[ACC_W-1:DATA_W-1]) || ~(|acc_shr[ACC_W-1:DATA_W-1])) begin
      y_sat = acc_shr[DATA_W-1:0];
    end else if (acc_shr[ACC_W-1]) begin
      y_sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      y_sat = {1'b0, {(DATA_W-1){1'b1}}};
    end
    y_out = y_sat;
`ifdef FC_RELU_EN
    if (y_sat[DATA_W-1]) begin
      y_out = '0;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    row_d       = row_q;
    w_addr_d    = w_addr_q;
    acc_d       = acc_q;
    pend_d      = pend_q;
    x_buf_d     = x_buf_q;
    busy        = 1'b0;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD_IN;
          idx_d    = '0;
          row_d    = '0;
          w_addr_d = ADDR_W'(W_BASE);
          acc_d    = '0;
          pend_d   = 1'b0;
        end
      end

      S_LOAD_IN: begin
        busy      = 1'b1;
        mem_addr  = ADDR_W'(IN_BASE) + ADDR_W'(idx_q);
        mem_rd_en = ~pend_q;
        if (!pend_q) begin
          pend_d = 1'b1;
        end
        if (rd_ok) begin
          pend_d         = 1'b0;
          x_buf_d[idx_q] = rd_data_s;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_ROW_BIAS;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_ROW_BIAS: begin
        busy      = 1'b1;
        mem_addr  = ADDR_W'(B_BASE) + ADDR_W'(row_q);
        mem_rd_en = ~pend_q;
        if (!pend_q) begin
          pend_d = 1'b1;
        end
        if (rd_ok) begin
          pend_d  = 1'b0;
          acc_d   = ACC_W'(rd_data_s) <<< FRAC_W;
          state_d = S_ROW_MAC;
        end
      end

      S_ROW_MAC: begin
        busy      = 1'b1;
        mem_addr  = w_addr_q;
        mem_rd_en = ~pend_q;
        if (!pend_q) begin
          pend_d = 1'b1;
        end
        if (rd_ok) begin
          pend_d   = 1'b0;
          acc_d    = acc_q + ACC_W'(prod);
          w_addr_d = w_addr_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_STORE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_STORE: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_addr    = ADDR_W'(OUT_BASE) + ADDR_W'(row_q);
        mem_wr_data = y_out;
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = S_FINISH;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_ROW_BIAS;
        end
      end

      S_FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      row_q    <= '0;
      w_addr_q <= '0;
      acc_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      w_addr_q <= w_addr_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
    end
  end

  // Input buffer needs no reset: every entry is rewritten before first use.
  always_ff @(posedge clk) begin
    x_buf_q <= x_buf_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_engine.sv
`default_nettype none
// tb_fc_layer_engine: scoreboard bench for fc_layer_engine with a 4->2 layer and a variable-latency memory model.
module tb_fc_layer_engine;

  localparam int DATA_W   = 16;
  localparam int FRAC_W   = 8;
  localparam int N_IN     = 4;
  localparam int N_OUT    = 2;
  localparam int ADDR_W   = 6;
  localparam int IN_BASE  = 0;
  localparam int W_BASE   = 4;
  localparam int B_BASE   = 12;
  localparam int OUT_BASE = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, mem_rd_en, mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_valid = 1'b0;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic [DATA_W-1:0] mem_wr_data;

  fc_layer_engine #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W),
    .IN_BASE(IN_BASE), .W_BASE(W_BASE), .B_BASE(B_BASE), .OUT_BASE(OUT_BASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
  typedef struct { int at; logic [25:0] exp; } probe_t;

  wr_t    exp_wr_q[$];
  int     exp_done_q[$];
  probe_t probe_q[$];

  logic [DATA_W-1:0] mem [64];
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int timeouts = 0;
  int viol = 0;
  int checks = 0;
  int errors = 0;
  bit lat_rand = 1'b0;
  bit fin_req = 1'b0;
  int next_lat = 1;
  int cnt = 0;
  bit outst = 1'b0;
  logic [ADDR_W-1:0] addr_l = '0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      next_lat <= lat_rand ? int'($urandom_range(1, 5)) : 1;
    end
  end

  // Memory model: one response per request after next_lat cycles; tracks read overlap.
  initial begin
    forever begin
      @(posedge clk);
      mem_rd_valid <= 1'b0;
      if (reset) begin
        cnt   <= 0;
        outst <= 1'b0;
      end else begin
        if (mem_rd_en && outst) viol <= viol + 1;
        outst <= mem_rd_en ? 1'b1 : (mem_rd_valid ? 1'b0 : outst);
        if (mem_rd_en) begin
          if (next_lat == 1) begin
            mem_rd_valid <= 1'b1;
            mem_rd_data  <= mem[mem_addr];
          end else begin
            cnt    <= next_lat - 1;
            addr_l <= mem_addr;
          end
        end else if (cnt == 1) begin
          mem_rd_valid <= 1'b1;
          mem_rd_data  <= mem[addr_l];
          cnt          <= 0;
        end else if (cnt > 1) begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // Monitor: the only process that compares and counts.
  initial begin
    wr_t    w;
    int     d;
    probe_t p;
    logic [25:0] act;
    forever begin
      @(negedge clk);
      if (mem_wr_en) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%0d data=%h, required no write", mem_addr, mem_wr_data);
        end else begin
          w = exp_wr_q.pop_front();
          if (mem_addr !== w.addr || mem_wr_data !== w.data) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                     mem_addr, mem_wr_data, w.addr, w.data);
          end
        end
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: at cycle %0d after start, required none", cyc - start_cyc);
        end else begin
          d = exp_done_q.pop_front();
          if (d >= 0 && (cyc - start_cyc) != d) begin
            errors++;
            $display("FAIL done_cycle: got %0d, required %0d", cyc - start_cyc, d);
          end
        end
      end
      while (probe_q.size() > 0 && probe_q[0].at <= cyc) begin
        p = probe_q.pop_front();
        act = {busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data};
        checks++;
        if (act !== p.exp) begin
          errors++;
          $display("FAIL idle_outputs: got %h, required %h", act, p.exp);
        end
      end
      if (fin_req) begin
        checks++;
        if (viol != 0) begin
          errors++;
          $display("FAIL read_overlap: got %0d overlapping reads, required 0", viol);
        end
        checks++;
        if (timeouts != 0) begin
          errors++;
          $display("FAIL done_timeout: got %0d timeouts, required 0", timeouts);
        end
        checks++;
        if (exp_wr_q.size() + exp_done_q.size() != 0) begin
          errors++;
          $display("FAIL leftover: got %0d writes and %0d dones missing, required 0",
                   exp_wr_q.size(), exp_done_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  task automatic load(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                      input logic [15:0] x3, input logic [15:0] w0, input logic [15:0] w1,
                      input logic [15:0] b0, input logic [15:0] b1);
    mem[IN_BASE+0] = x0;
    mem[IN_BASE+1] = x1;
    mem[IN_BASE+2] = x2;
    mem[IN_BASE+3] = x3;
    for (int i = 0; i < N_IN; i++) begin
      mem[W_BASE+i]      = w0;
      mem[W_BASE+N_IN+i] = w1;
    end
    mem[B_BASE+0] = b0;
    mem[B_BASE+1] = b1;
  endtask

  task automatic expect_out(input logic [15:0] y0, input logic [15:0] y1, input int done_at);
    wr_t w;
    w.addr = ADDR_W'(OUT_BASE);     w.data = y0; exp_wr_q.push_back(w);
    w.addr = ADDR_W'(OUT_BASE + 1); w.data = y1; exp_wr_q.push_back(w);
    exp_done_q.push_back(done_at);
  endtask

  task automatic launch();
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int k = 0; k < budget && done_cnt == d0; k++) @(posedge clk);
    if (done_cnt == d0) timeouts++;
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_basic();
    load(16'h0100, 16'h0200, 16'hFF00, 16'h0080, 16'h0100, 16'hFF00, 16'h0080, 16'h0000);
  endtask

  logic [15:0] y_neg_basic;
  logic [15:0] y_neg_sat;
  int s;

  initial begin
    probe_t p;
`ifdef FC_RELU_EN
    y_neg_basic = 16'h0000;
    y_neg_sat   = 16'h0000;
`else
    y_neg_basic = 16'hFD80;
    y_neg_sat   = 16'h8000;
`endif
    for (int i = 0; i < 64; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    p.at = cyc + 1; p.exp = '0; probe_q.push_back(p);
    repeat (2) @(posedge clk);
    #1;

    // Basic layer with fixed one-cycle read latency
    load_basic();
    expect_out(16'h0300, y_neg_basic, 31);
    launch();
    wait_done(100);

    // Positive and negative saturation
    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    expect_out(16'h7FFF, 16'h7FFF, 31);
    launch();
    wait_done(100);

    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'h0000);
    expect_out(y_neg_sat, y_neg_sat, 31);
    launch();
    wait_done(100);

    // Starts while busy and in the done cycle are ignored; the next start reruns
    load_basic();
    expect_out(16'h0300, y_neg_basic, 31);
    expect_out(16'h0300, y_neg_basic, 31);
    launch();
    s = start_cyc;
    wait_until(s + 5);  start = 1'b1; @(posedge clk); #1 start = 1'b0;
    wait_until(s + 20); start = 1'b1; @(posedge clk); #1 start = 1'b0;
    wait_until(s + 31); start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100);

    // Random read latency
    lat_rand = 1'b1;
    load_basic();
    expect_out(16'h0300, y_neg_basic, -1);
    launch();
    wait_done(400);
    lat_rand = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset in the middle of the first row's MAC phase
    load_basic();
    launch();
    s = start_cyc;
    wait_until(s + 12);
    reset = 1'b1;
    p.at = s + 13; p.exp = '0; probe_q.push_back(p);
    @(posedge clk); #1 reset = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    expect_out(16'h0300, y_neg_basic, 31);
    launch();
    wait_done(100);

    repeat (3) @(posedge clk);
    fin_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor_stalled: got no summary, required summary");
    $fatal(1);
  end

endmodule
`default_nettype wire
